// File: rtl/snake_collision_scan_if.sv
// Bus bundle for snake_collision_scan.
//   start       : request a collision check (acted on only when idle)
//   snakes      : segment k of snake i at [(i*SEGS+k)*SW +: SW], packed {x,y}, k=0 is the head
//   len         : length of snake i at [i*LW +: LW]
//   busy        : scan in progress (SCAN or DONE)
//   done        : one-cycle pulse, should_stop valid
//   should_stop : bit i set = snake i collided
// master = requester side, slave = the scanner.
interface snake_collision_scan_if #(
  parameter int NSNAKE = 2,
  parameter int SEGS   = 16,
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int LW     = 5
);
  localparam int SW = XW + YW;

  logic                       start;
  logic [NSNAKE*SEGS*SW-1:0]  snakes;
  logic [NSNAKE*LW-1:0]       len;
  logic                       busy;
  logic                       done;
  logic [NSNAKE-1:0]          should_stop;

  modport master (output start, snakes, len, input busy, done, should_stop);
  modport slave  (input start, snakes, len, output busy, done, should_stop);
endinterface

// File: rtl/snake_collision_scan.sv
// Sequential collision scanner for a multi-snake game board.
// On start the board snapshot is latched, then one (target snake, segment)
// pair is visited per clock; every head is compared against that segment in
// parallel and hits are OR-accumulated into sticky flags. The flags are
// published on should_stop together with a one-cycle done pulse.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : snake_collision_scan_if.slave (start/snakes/len in, busy/done/should_stop out)
//
// state  | meaning
// S_IDLE | waiting for start, inputs are sampled here only
// S_SCAN | walking (t,s) over NSNAKE*SEGS pairs, one per clock
// S_DONE | should_stop freshly loaded, done asserted for this cycle
module snake_collision_scan #(
  parameter int NSNAKE = 2,
  parameter int SEGS   = 16,
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int MAXX   = 29,
  parameter int MAXY   = 19,
  parameter int LW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_collision_scan_if.slave bus
);

  localparam int SW  = XW + YW;
  localparam int TW  = (NSNAKE > 1) ? $clog2(NSNAKE) : 1;
  localparam int SBW = (SEGS > 1) ? $clog2(SEGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [SBW-1:0]     s_q, s_d;
  logic [NSNAKE-1:0]  flags_q, flags_d;
  logic [NSNAKE-1:0]  stop_q, stop_d;
  logic [NSNAKE-1:0]  hit;
  logic               load;

  // Board snapshot; only meaningful after a load, so it carries no reset.
  logic [SW-1:0]      seg_q [NSNAKE][SEGS];
  logic [LW-1:0]      len_q [NSNAKE];

  logic [SW-1:0]      cur_seg;
  logic               seg_live;
  logic               first_idx;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NSNAKE; i++) begin
        for (int k = 0; k < SEGS; k++) begin
          seg_q[i][k] <= bus.snakes[(i*SEGS+k)*SW +: SW];
        end
        // Lengths beyond SEGS would point past the stored body.
        if (32'(bus.len[i*LW +: LW]) > 32'(SEGS)) begin
          len_q[i] <= LW'(SEGS);
        end else begin
          len_q[i] <= bus.len[i*LW +: LW];
        end
      end
    end
  end

  // Per-cycle hit vector: every head against segment s of snake t.
  always_comb begin
    hit       = '0;
    cur_seg   = seg_q[t_q][s_q];
    seg_live  = 32'(s_q) < 32'(len_q[t_q]);
    first_idx = (t_q == '0) && (s_q == '0);
    for (int i = 0; i < NSNAKE; i++) begin
      if (len_q[i] != '0) begin
        // A head trivially matches itself; exclude only that one pair.
        if (seg_live && !((t_q == TW'(i)) && (s_q == '0)) &&
            (seg_q[i][0] == cur_seg)) begin
          hit[i] = 1'b1;
        end
        // Wall test rides along with the first scan index.
        if (first_idx &&
            ((32'(seg_q[i][0][SW-1:YW]) > 32'(MAXX)) ||
             (32'(seg_q[i][0][YW-1:0])  > 32'(MAXY)))) begin
          hit[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    flags_d = flags_q;
    stop_d  = stop_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          t_d     = '0;
          s_d     = '0;
          flags_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        flags_d = flags_q | hit;
        if (s_q == SBW'(SEGS-1)) begin
          s_d = '0;
          if (t_q == TW'(NSNAKE-1)) begin
            t_d     = '0;
            stop_d  = flags_q | hit;  // include the final pair's result
            state_d = S_DONE;
          end else begin
            t_d = t_q + 1'b1;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      s_q     <= '0;
      flags_q <= '0;
      stop_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      s_q     <= s_d;
      flags_q <= flags_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.should_stop = stop_q;

endmodule
